// File: rtl/mapper_load_sequencer_if.sv
// Hypervisor write handshake into the mapper load sequencer.
// master = hypervisor side, slave = sequencer side.
interface mapper_load_sequencer_if;
  logic       hyp_wr_valid;
  logic       hyp_wr_ready;
  logic [1:0] hyp_wr_sel;
  logic       hyp_wr_map_sel;
  logic [7:0] hyp_wr_data;

  modport master (output hyp_wr_valid, hyp_wr_sel, hyp_wr_map_sel, hyp_wr_data,
                  input  hyp_wr_ready);
  modport slave  (input  hyp_wr_valid, hyp_wr_sel, hyp_wr_map_sel, hyp_wr_data,
                  output hyp_wr_ready);
endinterface

// File: rtl/mapper_load_sequencer.sv
// Sequences CPU MAP loads and queued hypervisor writes into the 4510 user mapper.
// Optional MAPSEQ_COALESCE_EN: same-register pushes overwrite the queue tail.
module mapper_load_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_map_active_i,
  input  logic                   cpu_load_a_i,
  input  logic                   cpu_load_x_i,
  input  logic                   cpu_load_y_i,
  input  logic                   cpu_load_z_i,
  input  logic                   cpu_load_map_sel_i,
  input  logic [7:0]             cpu_data_i,
  mapper_load_sequencer_if.slave hyp,
  input  logic                   mapper_busy_i,
  output logic                   load_a_o,
  output logic                   load_x_o,
  output logic                   load_y_o,
  output logic                   load_z_o,
  output logic                   load_map_sel_o,
  output logic [7:0]             map_data_o,
  output logic                   cpu_hold_o,
  output logic [CNT_W-1:0]       fifo_count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0] sel;
    logic       map_sel;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, CPU_MAP, DRAIN, WAIT_REFRESH} state_t;

  state_t           state_q, state_d;
  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, tail_idx;
  logic [CNT_W-1:0] count_q;
  logic             first_q, first_d;
  logic             zseen_q, zseen_d;
  logic             pend_vld_q;
  entry_t           pend_q, head, new_e;
  logic             full, pop, push, alloc, coal, tail_match;
  logic             cpu_path, cpu_any;

  assign head     = mem_q[rd_ptr_q];
  assign tail_idx = wr_ptr_q - PTR_W'(1);
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop      = (state_q == DRAIN) && !cpu_map_active_i && (count_q != '0);
  assign new_e    = '{sel: hyp.hyp_wr_sel, map_sel: hyp.hyp_wr_map_sel, data: hyp.hyp_wr_data};

`ifdef MAPSEQ_COALESCE_EN
  entry_t tail;
  assign tail = mem_q[tail_idx];
  // Z writes trigger a refresh each, so they must never merge; the tail
  // is off-limits once it is the entry leaving this cycle.
  assign tail_match = (count_q != '0) && (new_e.sel == tail.sel) &&
                      (new_e.map_sel == tail.map_sel) && (new_e.sel != 2'd0) &&
                      !(pop && (count_q == CNT_W'(1)));
`else
  assign tail_match = 1'b0;
`endif

  assign hyp.hyp_wr_ready = !full || tail_match;
  assign push  = hyp.hyp_wr_valid && hyp.hyp_wr_ready;
  assign coal  = push && tail_match;
  assign alloc = push && !tail_match;

  always_ff @(posedge clk) begin
    if (alloc)     mem_q[wr_ptr_q]      <= new_e;
    else if (coal) mem_q[tail_idx].data <= new_e.data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      first_q    <= 1'b0;
      zseen_q    <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      zseen_q    <= zseen_d;
      pend_vld_q <= pop;
      if (pop)   pend_q   <= head;
      if (alloc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    zseen_d = zseen_q;
    case (state_q)
      IDLE: begin
        zseen_d = 1'b0;
        if (cpu_map_active_i) begin
          state_d = CPU_MAP;
          zseen_d = cpu_load_z_i;
        end else if ((count_q != '0) && !mapper_busy_i) begin
          state_d = DRAIN;
        end
      end
      CPU_MAP: begin
        if (cpu_load_z_i) zseen_d = 1'b1;
        if (!cpu_map_active_i) begin
          if (zseen_q || cpu_load_z_i) begin
            state_d = WAIT_REFRESH;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (cpu_map_active_i) begin
          state_d = CPU_MAP;
          zseen_d = 1'b0;
        end else if (pop && (head.sel == 2'd0)) begin
          state_d = WAIT_REFRESH;
          first_d = 1'b1;
        end else if (count_q == '0) begin
          state_d = IDLE;
        end
      end
      WAIT_REFRESH: begin
        // busy only rises the cycle after load_z, so the first cycle cannot trust it
        if (!first_q && !mapper_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_path = (state_q == CPU_MAP) || ((state_q == IDLE) && cpu_map_active_i);
  assign cpu_any  = cpu_load_a_i | cpu_load_x_i | cpu_load_y_i | cpu_load_z_i;

  always_comb begin
    load_a_o       = 1'b0;
    load_x_o       = 1'b0;
    load_y_o       = 1'b0;
    load_z_o       = 1'b0;
    load_map_sel_o = 1'b0;
    map_data_o     = 8'h00;
    // a pending popped entry yields only to an actual CPU strobe
    if (cpu_path && (cpu_any || !pend_vld_q)) begin
      load_a_o       = cpu_load_a_i;
      load_x_o       = cpu_load_x_i;
      load_y_o       = cpu_load_y_i;
      load_z_o       = cpu_load_z_i;
      load_map_sel_o = cpu_load_map_sel_i;
      map_data_o     = cpu_data_i;
    end else if (pend_vld_q) begin
      load_a_o       = (pend_q.sel == 2'd3);
      load_x_o       = (pend_q.sel == 2'd2);
      load_y_o       = (pend_q.sel == 2'd1);
      load_z_o       = (pend_q.sel == 2'd0);
      load_map_sel_o = pend_q.map_sel;
      map_data_o     = pend_q.data;
    end
  end

  assign cpu_hold_o   = mapper_busy_i || (state_q == WAIT_REFRESH) || (state_q == DRAIN);
  assign fifo_count_o = count_q;
endmodule

// File: tb/tb_mapper_load_sequencer.sv
// Directed self-checking bench for mapper_load_sequencer.
module tb_mapper_load_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_map_active = 0, cpu_load_a = 0, cpu_load_x = 0, cpu_load_y = 0, cpu_load_z = 0;
  logic       cpu_load_map_sel = 0;
  logic [7:0] cpu_data = 8'h00;
  logic       mapper_busy = 0;
  logic       load_a, load_x, load_y, load_z, load_map_sel, cpu_hold;
  logic [7:0] map_data;
  logic [2:0] fifo_count;
  logic [3:0] loads;
  int         checks = 0, errors = 0;

  mapper_load_sequencer_if hif ();

  mapper_load_sequencer #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_map_active_i(cpu_map_active),
    .cpu_load_a_i(cpu_load_a), .cpu_load_x_i(cpu_load_x),
    .cpu_load_y_i(cpu_load_y), .cpu_load_z_i(cpu_load_z),
    .cpu_load_map_sel_i(cpu_load_map_sel), .cpu_data_i(cpu_data),
    .hyp(hif.slave),
    .mapper_busy_i(mapper_busy),
    .load_a_o(load_a), .load_x_o(load_x), .load_y_o(load_y), .load_z_o(load_z),
    .load_map_sel_o(load_map_sel), .map_data_o(map_data),
    .cpu_hold_o(cpu_hold), .fifo_count_o(fifo_count)
  );

  always #5 clk = ~clk;
  assign loads = {load_a, load_x, load_y, load_z};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic msel, input logic [7:0] data);
    hif.hyp_wr_valid   = 1'b1;
    hif.hyp_wr_sel     = sel;
    hif.hyp_wr_map_sel = msel;
    hif.hyp_wr_data    = data;
    tick();
    hif.hyp_wr_valid   = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_ld [4];
    logic [7:0] exp_dt [4];
    logic       exp_ms [4];
    int         ypulses;
    logic [7:0] ylast;
    hif.hyp_wr_valid = 1'b0;
    hif.hyp_wr_sel = 2'd0;
    hif.hyp_wr_map_sel = 1'b0;
    hif.hyp_wr_data = 8'h00;

    // T1: reset state, A then Z drain, hold until refresh done
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", hif.hyp_wr_ready, 1);
    chk("rst_loads", loads, 0);
    chk("rst_data", map_data, 0);
    chk("rst_msel", load_map_sel, 0);
    chk("rst_hold", cpu_hold, 0);
    push(2'd3, 1'b0, 8'h40);
    push(2'd0, 1'b0, 8'hF3);
    chk("t1_hold_drain", cpu_hold, 1);
    tick();
    chk("t1_load_a", loads, 4'b1000);
    chk("t1_data_a", map_data, 8'h40);
    tick();
    chk("t1_load_z", loads, 4'b0001);
    chk("t1_data_z", map_data, 8'hF3);
    mapper_busy = 1'b1;
    tick();
    chk("t1_hold_busy", cpu_hold, 1);
    chk("t1_loads_quiet", loads, 0);
    tick();
    mapper_busy = 1'b0;
    #1;
    chk("t1_hold_wait", cpu_hold, 1);
    tick();
    chk("t1_hold_release", cpu_hold, 0);
    chk("t1_count", fifo_count, 0);

    // T2: fill while busy, refuse 5th, drain in order
    mapper_busy = 1'b1;
    push(2'd3, 1'b0, 8'h01);
    push(2'd2, 1'b1, 8'h02);
    push(2'd1, 1'b0, 8'h03);
    push(2'd3, 1'b1, 8'h04);
    chk("t2_count_full", fifo_count, 4);
    chk("t2_ready_full", hif.hyp_wr_ready, 0);
    push(2'd2, 1'b0, 8'h99);
    chk("t2_count_refused", fifo_count, 4);
    mapper_busy = 1'b0;
    exp_ld = '{4'b1000, 4'b0100, 4'b0010, 4'b1000};
    exp_dt = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_ms = '{1'b0, 1'b1, 1'b0, 1'b1};
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t2_load%0d", i), loads, exp_ld[i]);
      chk($sformatf("t2_data%0d", i), map_data, exp_dt[i]);
      chk($sformatf("t2_msel%0d", i), load_map_sel, exp_ms[i]);
    end
    tick();
    chk("t2_idle_loads", loads, 0);
    chk("t2_idle_hold", cpu_hold, 0);
    chk("t2_idle_count", fifo_count, 0);

    // T3: CPU MAP passes through immediately, queue waits for MAP end
    mapper_busy = 1'b1;
    push(2'd2, 1'b0, 8'h21);
    push(2'd1, 1'b1, 8'h22);
    mapper_busy = 1'b0;
    cpu_map_active = 1'b1;
    cpu_load_a = 1'b1;
    cpu_load_map_sel = 1'b1;
    cpu_data = 8'h12;
    #1;
    chk("t3_cpu_load_a", loads, 4'b1000);
    chk("t3_cpu_data", map_data, 8'h12);
    chk("t3_cpu_msel", load_map_sel, 1);
    tick();
    cpu_load_a = 1'b0;
    #1;
    chk("t3_map_loads", loads, 0);
    chk("t3_map_count", fifo_count, 2);
    tick();
    chk("t3_map_count2", fifo_count, 2);
    cpu_map_active = 1'b0;
    cpu_load_map_sel = 1'b0;
    tick();
    chk("t3_after_count", fifo_count, 2);
    chk("t3_after_hold", cpu_hold, 0);
    tick();
    tick();
    chk("t3_load_x", loads, 4'b0100);
    chk("t3_data_x", map_data, 8'h21);
    tick();
    chk("t3_load_y", loads, 4'b0010);
    chk("t3_data_y", map_data, 8'h22);
    chk("t3_msel_y", load_map_sel, 1);
    tick();
    chk("t3_end_count", fifo_count, 0);

    // T4: Z pop, busy for 16 cycles starting one after pop
    mapper_busy = 1'b1;
    push(2'd0, 1'b1, 8'h55);
    mapper_busy = 1'b0;
    tick();
    chk("t4_hold_pop", cpu_hold, 1);
    tick();
    chk("t4_load_z", loads, 4'b0001);
    chk("t4_data_z", map_data, 8'h55);
    mapper_busy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("t4_hold_busy%0d", i), cpu_hold, 1);
    end
    tick();
    mapper_busy = 1'b0;
    #1;
    chk("t4_hold_tail", cpu_hold, 1);
    tick();
    chk("t4_hold_release", cpu_hold, 0);

    // T5: reset in the middle of a drain
    mapper_busy = 1'b1;
    push(2'd3, 1'b0, 8'hA1);
    push(2'd2, 1'b0, 8'hA2);
    push(2'd1, 1'b0, 8'hA3);
    mapper_busy = 1'b0;
    tick();
    chk("t5_draining_count", fifo_count, 3);
    chk("t5_draining_hold", cpu_hold, 1);
    reset = 1'b1;
    tick();
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_loads", loads, 0);
    chk("t5_rst_hold", cpu_hold, 0);
    reset = 1'b0;
    tick();
    chk("t5_post_loads", loads, 0);
    chk("t5_post_count", fifo_count, 0);

    // T6: two Y writes to the same map set
    mapper_busy = 1'b1;
    push(2'd1, 1'b1, 8'h10);
    push(2'd1, 1'b1, 8'h20);
`ifdef MAPSEQ_COALESCE_EN
    chk("t6_count", fifo_count, 1);
`else
    chk("t6_count", fifo_count, 2);
`endif
    mapper_busy = 1'b0;
    ypulses = 0;
    ylast = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (load_y) begin
        ypulses++;
        ylast = map_data;
      end
    end
`ifdef MAPSEQ_COALESCE_EN
    chk("t6_pulses", ypulses, 1);
`else
    chk("t6_pulses", ypulses, 2);
`endif
    chk("t6_last_data", ylast, 8'h20);
    chk("t6_end_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
